// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: frame geometry, FSM state encoding, baud divider.
// Parity support in the receiver is enabled by defining UART_RX_PARITY_EN.
package uart_rx_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   function automatic int calc_baud_cnt(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: serial line in, received byte and status strobes out.
interface uart_rx_if;
   import uart_rx_pkg::*;

   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_busy;
   logic                 frame_err;
   logic                 parity_err;

   modport master (
      input  rx,
      output rx_data, rx_valid, rx_busy, frame_err, parity_err
   );

   modport slave (
      output rx,
      input  rx_data, rx_valid, rx_busy, frame_err, parity_err
   );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus one extra flop for falling-edge detection.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_s,
   output logic fall
);

   logic sync_1;
   logic sync_2;
   logic sync_d;

   // Preset to idle-high so reset never fabricates a start edge on a quiet line.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         sync_d <= 1'b1;
      end else begin
         sync_1 <= rx;
         sync_2 <= sync_1;
         sync_d <= sync_2;
      end
   end

   assign rx_s = sync_2;
   assign fall = sync_d & ~sync_2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined); one midpoint sample per bit.
// state  | meaning
// IDLE   | waiting for a synchronised falling edge on rx
// START  | half bit-time wait, start bit re-checked (glitch rejection)
// DATA   | eight data bits sampled LSB first, one per bit-time
// PARITY | even-parity bit sampled (UART_RX_PARITY_EN only)
// STOP   | stop bit sampled, byte or error strobe issued
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   uart_rx_if.master  bus
);

   localparam int BAUD_CNT = calc_baud_cnt(CLK_FREQ, BAUD_RATE);
   localparam int CNT_W    = $clog2(BAUD_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_CNT / 2 - 1);
   localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

   logic rx_s;
   logic fall;

   uart_rx_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .rx   (bus.rx),
      .rx_s (rx_s),
      .fall (fall)
   );

   rx_state_t            state;
   rx_state_t            state_nx;
   logic [CNT_W-1:0]     baud_cnt;
   logic [2:0]           bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 half_tick;
   logic                 bit_tick;
   logic                 valid_nx;
   logic                 ferr_nx;
   logic                 perr_nx;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad;
`endif

   assign half_tick = (baud_cnt == CNT_HALF);
   assign bit_tick  = (baud_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (fall) state_nx = START;
         START: if (half_tick) state_nx = rx_s ? IDLE : DATA;
         DATA: begin
            if (bit_tick && bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
               state_nx = PARITY;
`else
               state_nx = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (bit_tick) state_nx = STOP;
`endif
         STOP:  if (bit_tick) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      valid_nx = 1'b0;
      ferr_nx  = 1'b0;
      perr_nx  = 1'b0;
      if (state == STOP && bit_tick) begin
         ferr_nx = ~rx_s;
`ifdef UART_RX_PARITY_EN
         perr_nx  = par_bad;
         valid_nx = rx_s & ~par_bad;
`else
         valid_nx = rx_s;
`endif
      end
   end

   assign bus.rx_busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         baud_cnt       <= '0;
         bit_cnt        <= '0;
         shift          <= '0;
         bus.rx_data    <= '0;
         bus.rx_valid   <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad        <= 1'b0;
`endif
      end else begin
         bus.rx_valid   <= valid_nx;
         bus.frame_err  <= ferr_nx;
         bus.parity_err <= perr_nx;
         if (valid_nx) bus.rx_data <= shift;

         // Counter restarts on every state change so each phase is timed from its own entry.
         if (state == IDLE || state_nx != state || bit_tick) baud_cnt <= '0;
         else                                                  baud_cnt <= baud_cnt + CNT_W'(1);

         if (state == START)                 bit_cnt <= '0;
         else if (state == DATA && bit_tick) bit_cnt <= bit_cnt + 3'd1;

         if (state == DATA && bit_tick) shift <= {rx_s, shift[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
         if (state == PARITY && bit_tick) par_bad <= (rx_s != ^shift);
`endif
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames against a frame-level model.
module tb_uart_rx;

   localparam int CLK_FREQ  = 1_600_000;
   localparam int BAUD_RATE = 100_000;
   localparam int BC        = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   // line start edge to rx_valid: 3 sync cycles + (frame bits - 0.5) bit-times
   localparam int LAT = 3 + ((2 * (9 + PAR) + 1) * BC) / 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   uart_rx_if bus ();

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int n_valid  = 0;
   int n_ferr   = 0;
   int n_perr   = 0;
   int valid_cyc = 0;
   logic [7:0] valid_data = 8'h00;
   logic prev_v = 1'b0, prev_f = 1'b0, prev_p = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rx_valid) begin
            n_valid++;
            valid_data = bus.rx_data;
            valid_cyc  = cyc;
            n_checks++;
            assert (bus.frame_err === 1'b0 && bus.parity_err === 1'b0) else begin
               n_fail++;
               $error("FAIL valid_excl: observed ferr=%b perr=%b expected 0 0", bus.frame_err, bus.parity_err);
            end
         end
         if (bus.frame_err)  n_ferr++;
         if (bus.parity_err) n_perr++;
         if (bus.rx_valid || bus.frame_err || bus.parity_err) begin
            n_checks++;
            assert (!(bus.rx_valid && prev_v) && !(bus.frame_err && prev_f) && !(bus.parity_err && prev_p)) else begin
               n_fail++;
               $error("FAIL pulse_width: observed two-cycle pulse v=%b f=%b p=%b expected single cycle", prev_v, prev_f, prev_p);
            end
         end
      end
      prev_v = bus.rx_valid;
      prev_f = bus.frame_err;
      prev_p = bus.parity_err;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic put_bit(input logic v);
      bus.rx = v;
      repeat (BC) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_bit,
                             output logic busy_mid, output int t0);
      t0 = cyc;
      busy_mid = 1'b0;
      put_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         put_bit(b[i]);
         if (i == 3) busy_mid = bus.rx_busy;
      end
      if (PAR == 1) put_bit(par_bit);
      put_bit(stop);
   endtask

   initial begin
      logic [7:0] model_data;
      logic [7:0] b;
      logic       busy_mid;
      logic       stop;
      logic       par_ok;
      int         t0;
      int         v0, f0, p0;

      bus.rx = 1'b1;
      rst    = 1'b1;
      idle(3);
      chk("reset_data",  32'(bus.rx_data), 32'h00);
      chk("reset_valid", 32'(bus.rx_valid), 32'h0);
      chk("reset_busy",  32'(bus.rx_busy), 32'h0);
      chk("reset_ferr",  32'(bus.frame_err), 32'h0);
      chk("reset_perr",  32'(bus.parity_err), 32'h0);
      rst = 1'b0;
      model_data = 8'h00;
      idle(4);

      // single good byte
      v0 = n_valid; f0 = n_ferr;
      send_frame(8'hA5, 1'b1, ^8'hA5, busy_mid, t0);
      idle(4);
      chk("a5_count",   32'(n_valid - v0), 32'd1);
      chk("a5_data",    32'(bus.rx_data), 32'hA5);
      chk("a5_ferr",    32'(n_ferr - f0), 32'd0);
      chk("a5_busy",    32'(bus.rx_busy), 32'h0);
      chk("a5_busymid", 32'(busy_mid), 32'h1);
      chk("a5_latency", 32'(valid_cyc - t0), 32'(LAT));
      model_data = 8'hA5;

      // short low glitch is rejected at the start-bit midpoint
      v0 = n_valid; f0 = n_ferr;
      bus.rx = 1'b0;
      idle(BC / 4);
      bus.rx = 1'b1;
      idle(3);
      chk("glitch_busy_hi", 32'(bus.rx_busy), 32'h1);
      idle(BC);
      chk("glitch_busy_lo", 32'(bus.rx_busy), 32'h0);
      chk("glitch_valid",   32'(n_valid - v0), 32'd0);
      chk("glitch_ferr",    32'(n_ferr - f0), 32'd0);

      // framing error followed by a held-low break
      v0 = n_valid; f0 = n_ferr;
      send_frame(8'h3C, 1'b0, ^8'h3C, busy_mid, t0);
      idle(5 * BC);
      chk("ferr_count", 32'(n_ferr - f0), 32'd1);
      chk("ferr_valid", 32'(n_valid - v0), 32'd0);
      chk("ferr_data",  32'(bus.rx_data), 32'(model_data));
      chk("break_busy", 32'(bus.rx_busy), 32'h0);
      bus.rx = 1'b1;
      idle(2 * BC);
      chk("break_ferr",  32'(n_ferr - f0), 32'd1);
      chk("break_valid", 32'(n_valid - v0), 32'd0);

      // back-to-back frames with no idle gap
      v0 = n_valid;
      send_frame(8'h00, 1'b1, 1'b0, busy_mid, t0);
      chk("b2b_first", 32'(valid_data), 32'h00);
      send_frame(8'hFF, 1'b1, 1'b0, busy_mid, t0);
      idle(4);
      chk("b2b_count", 32'(n_valid - v0), 32'd2);
      chk("b2b_data",  32'(bus.rx_data), 32'hFF);
      model_data = 8'hFF;

      // reset during bit 4 of 0x81
      v0 = n_valid; f0 = n_ferr; p0 = n_perr;
      put_bit(1'b0);
      put_bit(1'b1);
      put_bit(1'b0);
      put_bit(1'b0);
      put_bit(1'b0);
      bus.rx = 1'b0;
      idle(BC / 2);
      rst = 1'b1;
      bus.rx = 1'b1;
      idle(2);
      chk("rst_data",  32'(bus.rx_data), 32'h00);
      chk("rst_busy",  32'(bus.rx_busy), 32'h0);
      chk("rst_valid", 32'(bus.rx_valid), 32'h0);
      chk("rst_ferr",  32'(bus.frame_err), 32'h0);
      rst = 1'b0;
      model_data = 8'h00;
      idle(3 * BC);
      chk("rst_nopulse", 32'(n_valid - v0 + n_ferr - f0 + n_perr - p0), 32'd0);
      send_frame(8'h81, 1'b1, ^8'h81, busy_mid, t0);
      idle(4);
      chk("rst_next_count", 32'(n_valid - v0), 32'd1);
      chk("rst_next_data",  32'(bus.rx_data), 32'h81);
      model_data = 8'h81;

`ifdef UART_RX_PARITY_EN
      v0 = n_valid; p0 = n_perr;
      send_frame(8'h07, 1'b1, 1'b0, busy_mid, t0);
      idle(4);
      chk("par_bad_perr",  32'(n_perr - p0), 32'd1);
      chk("par_bad_valid", 32'(n_valid - v0), 32'd0);
      chk("par_bad_data",  32'(bus.rx_data), 32'(model_data));
      v0 = n_valid; p0 = n_perr;
      send_frame(8'h07, 1'b1, 1'b1, busy_mid, t0);
      idle(4);
      chk("par_ok_valid", 32'(n_valid - v0), 32'd1);
      chk("par_ok_perr",  32'(n_perr - p0), 32'd0);
      chk("par_ok_data",  32'(bus.rx_data), 32'h07);
      model_data = 8'h07;
`endif

      // random frames against the frame-level model
      for (int k = 0; k < 24; k++) begin
         b      = 8'($urandom);
         stop   = ($urandom_range(0, 3) != 0);
         par_ok = (PAR == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         v0 = n_valid; f0 = n_ferr; p0 = n_perr;
         send_frame(b, stop, (^b) ^ ~par_ok, busy_mid, t0);
         bus.rx = 1'b1;
         idle(BC + $urandom_range(0, BC));
         if (stop && par_ok) model_data = b;
         chk("rnd_valid", 32'(n_valid - v0), 32'(stop && par_ok));
         chk("rnd_ferr",  32'(n_ferr - f0), 32'(!stop));
         chk("rnd_perr",  32'(n_perr - p0), 32'(PAR == 1 && !par_ok));
         chk("rnd_data",  32'(bus.rx_data), 32'(model_data));
         chk("rnd_busy",  32'(bus.rx_busy), 32'h0);
         if (stop && par_ok) chk("rnd_latency", 32'(valid_cyc - t0), 32'(LAT));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
